// File: rtl/bcd_serial_seq.sv
// Serial multi-byte packed-BCD add/subtract sequencer.
// One byte (two digits) per clock goes through a shared bcd_addsub slice.
// The carry or borrow is chained from byte to byte.

// Two-digit BCD add/subtract slice with carry/borrow in and out.
// flags[1] is the carry (add) or borrow (sub) out. flags[0] is set when r == 0.
module bcd_addsub (
    input  logic       sub,
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       cin,
    output logic [7:0] r,
    output logic [1:0] flags
);
    // Ripple through the two digits.
    // Add: correct by +6 when the raw digit sum exceeds 9.
    // Sub: correct by -6 when the raw digit difference goes negative.
    always_comb begin
        logic       c;
        logic [4:0] raw;
        c   = cin;
        raw = '0;
        r   = '0;
        for (int d = 0; d < 2; d++) begin
            if (!sub) begin
                raw = {1'b0, a[4*d +: 4]} + {1'b0, b[4*d +: 4]} + {4'b0, c};
                if (raw > 5'd9) begin
                    raw = raw + 5'd6;
                    c   = 1'b1;
                end else begin
                    c   = 1'b0;
                end
            end else begin
                raw = {1'b0, a[4*d +: 4]} - {1'b0, b[4*d +: 4]} - {4'b0, c};
                if (raw[4]) begin
                    raw = raw - 5'd6;
                    c   = 1'b1;
                end else begin
                    c   = 1'b0;
                end
            end
            r[4*d +: 4] = raw[3:0];
        end
        flags = {c, (r == 8'h00)};
    end
endmodule

module bcd_serial_seq #(
    parameter int NBYTES = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  add_sub,
    input  logic                  cin,
    input  logic [8*NBYTES-1:0]   a_in,
    input  logic [8*NBYTES-1:0]   b_in,
    output logic                  busy,
    output logic                  done,
    output logic [8*NBYTES-1:0]   result,
    output logic                  carry_out,
    output logic                  zero
);
    localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [IW-1:0] LAST = IW'(NBYTES - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                    state, nxt;
    logic [NBYTES-1:0][7:0]    a_q, b_q, res_q;
    logic                      sub_q;
    logic                      carry_q;
    logic                      zacc;
    logic [IW-1:0]             idx;
    logic                      accept;
    logic                      last;
    logic [7:0]                byte_r;
    logic [1:0]                byte_flags;

    assign accept = start && (state != RUN);
    assign last   = (idx == LAST);
    assign busy   = (state == RUN);
    assign done   = (state == DONE);
    assign result = res_q;

    bcd_addsub u_addsub (
        .sub   (sub_q),
        .a     (a_q[idx]),
        .b     (b_q[idx]),
        .cin   (carry_q),
        .r     (byte_r),
        .flags (byte_flags)
    );

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= nxt;
    end

    // Next-state logic. DONE lasts one cycle unless a new start arrives in it.
    always_comb begin
        nxt = state;
        case (state)
            IDLE:    if (start) nxt = RUN;
            RUN:     if (last)  nxt = DONE;
            DONE:    nxt = start ? RUN : IDLE;
            default: nxt = IDLE;
        endcase
    end

    // Datapath. Latch the operands on accept, then write one result byte per RUN cycle.
    // Final flags are captured on the last byte so they hold steady after DONE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_q       <= '0;
            b_q       <= '0;
            res_q     <= '0;
            sub_q     <= 1'b0;
            carry_q   <= 1'b0;
            zacc      <= 1'b0;
            idx       <= '0;
            carry_out <= 1'b0;
            zero      <= 1'b0;
        end else if (accept) begin
            a_q     <= a_in;
            b_q     <= b_in;
            sub_q   <= add_sub;
            carry_q <= cin;
            zacc    <= 1'b1;
            idx     <= '0;
        end else if (state == RUN) begin
            res_q[idx] <= byte_r;
            carry_q    <= byte_flags[1];
            zacc       <= zacc & byte_flags[0];
            if (last) begin
                carry_out <= byte_flags[1];
                zero      <= zacc & byte_flags[0];
            end else begin
                idx <= idx + IW'(1);
            end
        end
    end
endmodule

// File: tb/tb_bcd_serial_seq.sv
// Randomized self-checking bench for bcd_serial_seq.
// The reference model converts operands to decimal integers and does plain arithmetic.
// u_big uses NBYTES=4 and u_small uses NBYTES=1.
module tb_bcd_serial_seq;
    localparam int N = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        start, add_sub, cin;
    logic [31:0] a_in, b_in, result;
    logic        busy, done, carry_out, zero;
    logic        start1, add_sub1, cin1;
    logic [7:0]  a1, b1, result1;
    logic        busy1, done1, carry_out1, zero1;

    int errs = 0;
    int checks = 0;

    bcd_serial_seq #(.NBYTES(N)) u_big (
        .clk(clk), .reset(reset), .start(start), .add_sub(add_sub), .cin(cin),
        .a_in(a_in), .b_in(b_in), .busy(busy), .done(done), .result(result),
        .carry_out(carry_out), .zero(zero)
    );

    bcd_serial_seq #(.NBYTES(1)) u_small (
        .clk(clk), .reset(reset), .start(start1), .add_sub(add_sub1), .cin(cin1),
        .a_in(a1), .b_in(b1), .busy(busy1), .done(done1), .result(result1),
        .carry_out(carry_out1), .zero(zero1)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic longint bcd2int(input logic [31:0] v, input int nd);
        longint r = 0;
        for (int i = nd - 1; i >= 0; i--) r = r * 10 + longint'((v >> (4 * i)) & 32'hF);
        return r;
    endfunction

    function automatic logic [31:0] int2bcd(input longint v, input int nd);
        logic [31:0] r = '0;
        for (int i = 0; i < nd; i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    function automatic logic [31:0] rbcd(input int nd);
        logic [31:0] r = '0;
        for (int i = 0; i < nd; i++) r[4*i +: 4] = 4'($urandom_range(0, 9));
        return r;
    endfunction

    // Decimal reference: wrap the value modulo 10^(2*nb) and report the carry or borrow.
    task automatic model(input int nb, input logic [31:0] a, input logic [31:0] b,
                         input bit sub, input bit ci,
                         output logic [31:0] r, output bit c);
        longint m = 1;
        longint s;
        repeat (2 * nb) m = m * 10;
        if (sub) s = bcd2int(a, 2 * nb) - bcd2int(b, 2 * nb) - longint'(ci);
        else     s = bcd2int(a, 2 * nb) + bcd2int(b, 2 * nb) + longint'(ci);
        c = sub ? (s < 0) : (s >= m);
        if (s < 0)  s = s + m;
        if (s >= m) s = s - m;
        r = int2bcd(s, 2 * nb);
    endtask

    task automatic drive(input bit sm, input bit st, input logic [31:0] a, input logic [31:0] b,
                         input bit sub, input bit ci);
        if (sm) begin
            start1 = st; a1 = a[7:0]; b1 = b[7:0]; add_sub1 = sub; cin1 = ci;
        end else begin
            start = st; a_in = a; b_in = b; add_sub = sub; cin = ci;
        end
    endtask

    // One complete operation. Checks latency, busy length, result and both flags.
    task automatic run_op(input bit sm, input logic [31:0] a, input logic [31:0] b,
                          input bit sub, input bit ci, input string tag);
        int          nb = sm ? 1 : N;
        logic [31:0] er;
        bit          ec;
        int          n = 0;
        int          bn = 0;
        bit          seen = 0;
        model(nb, a, b, sub, ci, er, ec);
        @(negedge clk);
        drive(sm, 1'b1, a, b, sub, ci);
        while (!seen && n < 50) begin
            @(negedge clk);
            n++;
            if (n == 1) begin
                if (sm) start1 = 1'b0;
                else    start  = 1'b0;
            end
            if (sm ? busy1 : busy) bn++;
            if (sm ? done1 : done) seen = 1;
        end
        chk({tag, "_done"}, 64'(seen), 64'd1);
        chk({tag, "_lat"}, 64'(n), 64'(nb + 1));
        chk({tag, "_busy"}, 64'(bn), 64'(nb));
        chk({tag, "_res"}, sm ? 64'(result1) : 64'(result), 64'(er));
        chk({tag, "_cy"}, sm ? 64'(carry_out1) : 64'(carry_out), 64'(ec));
        chk({tag, "_zero"}, sm ? 64'(zero1) : 64'(zero), 64'(er == 0));
    endtask

    initial begin
        logic [31:0] e;
        bit          ec;
        int          n;
        int          cnt;
        bit          seen;

        reset = 1'b1;
        drive(0, 0, '0, '0, 0, 0);
        drive(1, 0, '0, '0, 0, 0);
        #12;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_res", 64'(result), 64'd0);
        chk("rst_cy", 64'(carry_out), 64'd0);
        chk("rst_zero", 64'(zero), 64'd0);
        chk("rst_small_res", 64'(result1), 64'd0);
        @(negedge clk);
        reset = 1'b0;

        // Directed cases.
        run_op(0, 32'h12345678, 32'h87654321, 0, 0, "add_9s");
        run_op(0, 32'h99999999, 32'h00000001, 0, 0, "add_wrap");
        run_op(0, 32'h00001000, 32'h00000001, 1, 0, "sub_999");
        run_op(0, 32'h00000000, 32'h00000001, 1, 0, "sub_under");
        run_op(1, 32'h45, 32'h55, 0, 1, "n1_add");

        // A start during RUN is ignored.
        model(N, 32'h11111111, 32'h22222222, 0, 0, e, ec);
        @(negedge clk);
        drive(0, 1, 32'h11111111, 32'h22222222, 0, 0);
        n = 0; seen = 0;
        while (!seen && n < 50) begin
            @(negedge clk);
            n++;
            if (n == 1) start = 1'b0;
            if (n == 2) drive(0, 1, 32'h55555555, 32'h33333333, 1, 1);
            if (n == 3) start = 1'b0;
            if (done) seen = 1;
        end
        chk("ign_lat", 64'(n), 64'(N + 1));
        chk("ign_res", 64'(result), 64'(e));

        // Hold start high through DONE so the second op is accepted back-to-back.
        model(N, 32'h00000500, 32'h00000500, 0, 0, e, ec);
        @(negedge clk);
        drive(0, 1, 32'h00000500, 32'h00000500, 0, 0);
        n = 0; seen = 0;
        while (!seen && n < 50) begin
            @(negedge clk);
            n++;
            if (n == 1) drive(0, 1, 32'h50000000, 32'h60000000, 0, 1);
            if (done) seen = 1;
        end
        chk("b2b_res1", 64'(result), 64'(e));
        model(N, 32'h50000000, 32'h60000000, 0, 1, e, ec);
        n = 0; seen = 0;
        while (!seen && n < 50) begin
            @(negedge clk);
            n++;
            if (n == 1) start = 1'b0;
            if (done) seen = 1;
        end
        chk("b2b_lat2", 64'(n), 64'(N + 1));
        chk("b2b_res2", 64'(result), 64'(e));
        chk("b2b_cy2", 64'(carry_out), 64'(ec));
        cnt = 0;
        repeat (8) begin
            @(negedge clk);
            if (done) cnt++;
        end
        chk("b2b_extra_done", 64'(cnt), 64'd0);

        // Reset mid-RUN, after two bytes have been processed.
        @(negedge clk);
        drive(0, 1, 32'h12121212, 32'h34343434, 0, 0);
        repeat (3) begin
            @(negedge clk);
            start = 1'b0;
        end
        reset = 1'b1;
        #1;
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_done", 64'(done), 64'd0);
        chk("abort_res", 64'(result), 64'd0);
        chk("abort_flags", 64'({carry_out, zero}), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        cnt = 0;
        repeat (8) begin
            @(negedge clk);
            if (done) cnt++;
        end
        chk("abort_no_done", 64'(cnt), 64'd0);
        run_op(0, 32'h00000001, 32'h00000001, 1, 0, "after_abort");

        // Random valid-BCD operands on both instances.
        for (int i = 0; i < 20; i++) begin
            run_op(0, rbcd(8), rbcd(8), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), "rnd4");
            run_op(1, rbcd(2), rbcd(2), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), "rnd1");
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
